dp3_sweep_ctrl: RTL and testbench



---
 rtl/dp3_sweep_ctrl_pkg.sv | 25 ++
 rtl/dp3_sweep_ctrl_if.sv | 60 ++++++
 rtl/dp3_sweep_ctrl_idx_walk.sv | 48 ++++
 rtl/dp3_sweep_ctrl.sv | 120 ++++++++++++
 tb/tb_dp3_sweep_ctrl.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/dp3_sweep_ctrl_pkg.sv
// Shared types for the 3D alignment sweep sequencer.
// States, default widths, score floor and the lattice coordinate bundle.
package dp3_pkg;

  localparam int IDX_W   = 8;
  localparam int SCORE_W = 12;

  localparam logic signed [SCORE_W-1:0] SCORE_MIN =
    {1'b1, {(SCORE_W-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CALC,
    WRITE,
    DONE
  } sweep_state_t;

  typedef struct packed {
    logic [IDX_W-1:0] i;
    logic [IDX_W-1:0] j;
    logic [IDX_W-1:0] k;
  } coord_t;

endpackage

// File: rtl/dp3_sweep_ctrl_if.sv
// Host, score-store and datapath signals of the sweep sequencer.
// Optional abort/aborted pair exists only when ABORT_EN is defined.
interface dp3_sweep_ctrl_if #(
  parameter int IDX_W   = 8,
  parameter int SCORE_W = 12
);

  logic                      start;
  logic [IDX_W-1:0]          len_x;
  logic [IDX_W-1:0]          len_y;
  logic [IDX_W-1:0]          len_z;
  logic                      busy;
  logic                      done;
  logic [IDX_W-1:0]          cell_i;
  logic [IDX_W-1:0]          cell_j;
  logic [IDX_W-1:0]          cell_k;
  logic                      rd_req;
  logic                      rd_ack;
  logic                      cap_en;
  logic                      wr_req;
  logic                      wr_ack;
  logic signed [SCORE_W-1:0] score_in;
  logic signed [SCORE_W-1:0] best_score;
  logic [IDX_W-1:0]          best_i;
  logic [IDX_W-1:0]          best_j;
  logic [IDX_W-1:0]          best_k;
`ifdef ABORT_EN
  logic                      abort;
  logic                      aborted;
`endif

  modport slave (
`ifdef ABORT_EN
    input  abort,
    output aborted,
`endif
    input  start, len_x, len_y, len_z,
    input  rd_ack, wr_ack, score_in,
    output busy, done,
    output cell_i, cell_j, cell_k,
    output rd_req, cap_en, wr_req,
    output best_score,
    output best_i, best_j, best_k
  );

  modport master (
`ifdef ABORT_EN
    output abort,
    input  aborted,
`endif
    output start, len_x, len_y, len_z,
    output rd_ack, wr_ack, score_in,
    input  busy, done,
    input  cell_i, cell_j, cell_k,
    input  rd_req, cap_en, wr_req,
    input  best_score,
    input  best_i, best_j, best_k
  );

endinterface

// File: rtl/dp3_sweep_ctrl_idx_walk.sv
// Raster (i,j,k) lattice walker, k fastest; 1-based indices.
// Shared with the traceback sequencer.
module dp3_idx_walk
  import dp3_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load_i,
  input  logic   inc_i,
  input  coord_t len_i,
  output coord_t idx_o,
  output logic   last_o
);

  localparam logic [IDX_W-1:0] ONE = IDX_W'(1);

  coord_t idx_q, idx_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) idx_q <= '0;
    else     idx_q <= idx_d;
  end

  always_comb begin
    idx_d = idx_q;
    unique case (1'b1)
      load_i: idx_d = '{i: ONE, j: ONE, k: ONE};
      inc_i: begin
        if (idx_q.k == len_i.k) begin
          idx_d.k = ONE;
          if (idx_q.j == len_i.j) begin
            idx_d.j = ONE;
            idx_d.i = idx_q.i + ONE;
          end else begin
            idx_d.j = idx_q.j + ONE;
          end
        end else begin
          idx_d.k = idx_q.k + ONE;
        end
      end
      default: ;
    endcase
  end

  assign idx_o  = idx_q;
  assign last_o = (idx_q == len_i);

endmodule

// File: rtl/dp3_sweep_ctrl.sv
// Fetch/compute/write sequencer for the 3D affine-gap cell datapath.
// Define ABORT_EN to add the abort input and aborted pulse.
module dp3_sweep_ctrl
  import dp3_pkg::*;
#(
  parameter int IDX_W    = dp3_pkg::IDX_W,
  parameter int SCORE_W  = dp3_pkg::SCORE_W,
  parameter int CELL_LAT = 2
) (
  input logic             clk,
  input logic             rst,
  dp3_sweep_ctrl_if.slave bus
);

  localparam int CNT_W = (CELL_LAT > 1) ? $clog2(CELL_LAT) : 1;
  localparam logic [IDX_W-1:0] ZERO = '0;
  localparam logic signed [SCORE_W-1:0] SMIN =
    {1'b1, {(SCORE_W-1){1'b0}}};

  sweep_state_t              state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  coord_t                    len_q, len_d;
  logic signed [SCORE_W-1:0] best_q, best_d;
  coord_t                    bpos_q, bpos_d;
  coord_t                    idx;
  logic                      last;
  logic                      load, zero_len;
  logic                      abort_hit, rd_fire, wr_fire;

`ifdef ABORT_EN
  logic aborted_q;
  assign abort_hit   = bus.abort & (state_q != IDLE);
  assign bus.aborted = aborted_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) aborted_q <= 1'b0;
    else     aborted_q <= abort_hit;
  end
`else
  assign abort_hit = 1'b0;
`endif

  assign load     = (state_q == IDLE) & bus.start;
  assign zero_len = (bus.len_x == ZERO) | (bus.len_y == ZERO)
                  | (bus.len_z == ZERO);
  // Abort wins over an ack landing in the same cycle.
  assign rd_fire  = bus.rd_req & bus.rd_ack & ~abort_hit;
  assign wr_fire  = bus.wr_req & bus.wr_ack & ~abort_hit;

  dp3_idx_walk u_walk (
    .clk    (clk),
    .rst    (rst),
    .load_i (load),
    .inc_i  (wr_fire),
    .len_i  (len_q),
    .idx_o  (idx),
    .last_o (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      best_q  <= '0;
      bpos_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      best_q  <= best_d;
      bpos_q  <= bpos_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:  if (bus.start) state_d = zero_len ? DONE : FETCH;
      FETCH: if (rd_fire) begin
        cnt_d   = CNT_W'(CELL_LAT - 1);
        state_d = CALC;
      end
      CALC:  if (cnt_q == '0) state_d = WRITE;
             else             cnt_d   = cnt_q - 1'b1;
      WRITE: if (wr_fire) state_d = last ? DONE : FETCH;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_hit) state_d = IDLE;
  end

  always_comb begin
    len_d  = len_q;
    best_d = best_q;
    bpos_d = bpos_q;
    if (load) begin
      len_d  = '{i: bus.len_x, j: bus.len_y, k: bus.len_z};
      best_d = SMIN;
      bpos_d = '0;
    end else if (wr_fire && (bus.score_in > best_q)) begin
      best_d = bus.score_in;
      bpos_d = idx;
    end
  end

  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = (state_q == DONE);
  assign bus.rd_req     = (state_q == FETCH);
  assign bus.wr_req     = (state_q == WRITE);
  assign bus.cap_en     = rd_fire;
  assign bus.cell_i     = idx.i;
  assign bus.cell_j     = idx.j;
  assign bus.cell_k     = idx.k;
  assign bus.best_score = best_q;
  assign bus.best_i     = bpos_q.i;
  assign bus.best_j     = bpos_q.j;
  assign bus.best_k     = bpos_q.k;

endmodule

// File: tb/tb_dp3_sweep_ctrl.sv
// Directed bench for dp3_sweep_ctrl with a write-order scoreboard.
// Covers ABORT_EN when the macro is defined.
module tb_dp3_sweep_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  typedef struct {
    int i;
    int j;
    int k;
    int s;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  dp3_sweep_ctrl_if #(.IDX_W(8), .SCORE_W(12)) bus ();

  dp3_sweep_ctrl #(
    .IDX_W    (8),
    .SCORE_W  (12),
    .CELL_LAT (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(string tag, logic signed [31:0] obs,
                     logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic run(string nm, int lx, int ly, int lz,
                     int rdd, int wrd, int mode, int exp_done,
                     int eb, int ebi, int ebj, int ebk, bit poke);
    int n = 0;
    int cyc, rd_cnt, wr_cnt, hs;
    bit seen;
    bit p_rd, p_rack, p_wr, p_wack;
    exp_t e;
    int tbl[3] = '{7, 7, 3};
    q.delete();
    for (int i = 1; i <= lx; i++)
      for (int j = 1; j <= ly; j++)
        for (int k = 1; k <= lz; k++) begin
          e.i = i; e.j = j; e.k = k;
          case (mode)
            0:       e.s = 5;
            1:       e.s = i + j + k;
            default: e.s = tbl[n % 3];
          endcase
          q.push_back(e);
          n++;
        end
    @(negedge clk);
    bus.start = 1'b1;
    bus.len_x = 8'(lx);
    bus.len_y = 8'(ly);
    bus.len_z = 8'(lz);
    @(posedge clk);
    #1 bus.start = 1'b0;
    cyc = 1; rd_cnt = 0; wr_cnt = 0; hs = 0; seen = 1'b0;
    p_rd = 1'b0; p_rack = 1'b0; p_wr = 1'b0; p_wack = 1'b0;
    while (!seen && cyc <= 400) begin
      @(negedge clk);
      bus.rd_ack = bus.rd_req && (rd_cnt >= rdd);
      bus.wr_ack = bus.wr_req && (wr_cnt >= wrd);
      bus.score_in = (bus.wr_req && q.size() > 0) ? 12'(q[0].s) : 12'sd0;
      bus.start = poke && (cyc == 3);
      #1;
      chk({nm, ":excl"}, bus.rd_req & bus.wr_req, 0);
      chk({nm, ":cap_en"}, bus.cap_en, bus.rd_req & bus.rd_ack);
      if (p_rd && !p_rack) chk({nm, ":rd_hold"}, bus.rd_req, 1);
      if (p_wr && !p_wack) chk({nm, ":wr_hold"}, bus.wr_req, 1);
      if ((bus.rd_req || bus.wr_req) && q.size() > 0) begin
        chk({nm, ":cell_i"}, bus.cell_i, q[0].i);
        chk({nm, ":cell_j"}, bus.cell_j, q[0].j);
        chk({nm, ":cell_k"}, bus.cell_k, q[0].k);
      end
      if (bus.rd_ack) hs++;
      if (bus.wr_req && bus.wr_ack) begin
        if (q.size() == 0) chk({nm, ":extra_wr"}, 1, 0);
        else void'(q.pop_front());
      end
      if (bus.done) begin
        chk({nm, ":done_cyc"}, cyc, exp_done);
        seen = 1'b1;
      end
      rd_cnt = bus.rd_ack ? 0 : (bus.rd_req ? rd_cnt + 1 : 0);
      wr_cnt = bus.wr_ack ? 0 : (bus.wr_req ? wr_cnt + 1 : 0);
      p_rd = bus.rd_req; p_rack = bus.rd_ack;
      p_wr = bus.wr_req; p_wack = bus.wr_ack;
      cyc++;
    end
    bus.start = 1'b0;
    chk({nm, ":done_seen"}, seen, 1);
    chk({nm, ":fetches"}, hs, lx * ly * lz);
    chk({nm, ":sb_empty"}, q.size(), 0);
    chk({nm, ":best"}, bus.best_score, eb);
    if (ebi >= 0) begin
      chk({nm, ":best_i"}, bus.best_i, ebi);
      chk({nm, ":best_j"}, bus.best_j, ebj);
      chk({nm, ":best_k"}, bus.best_k, ebk);
    end
    @(negedge clk);
    bus.rd_ack = 1'b0;
    bus.wr_ack = 1'b0;
    #1;
    chk({nm, ":idle_busy"}, bus.busy, 0);
    chk({nm, ":idle_done"}, bus.done, 0);
    chk({nm, ":best_hold"}, bus.best_score, eb);
  endtask

  initial begin
    int t;
    bus.start = 1'b0;
    bus.len_x = '0;
    bus.len_y = '0;
    bus.len_z = '0;
    bus.rd_ack = 1'b0;
    bus.wr_ack = 1'b0;
    bus.score_in = '0;
`ifdef ABORT_EN
    bus.abort = 1'b0;
`endif
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_rd", bus.rd_req, 0);
    chk("rst_wr", bus.wr_req, 0);
    chk("rst_cap", bus.cap_en, 0);
    chk("rst_cell", {bus.cell_i, bus.cell_j, bus.cell_k}, 0);
    chk("rst_best", bus.best_score, 0);
    chk("rst_bpos", {bus.best_i, bus.best_j, bus.best_k}, 0);
    rst = 1'b0;

    run("c111", 1, 1, 1, 0, 0, 0, 5, 5, 1, 1, 1, 1'b0);
    run("c222", 2, 2, 2, 0, 0, 1, 33, 6, 2, 2, 2, 1'b0);
    run("slow", 1, 1, 3, 3, 2, 1, 28, 5, 1, 1, 3, 1'b0);
    run("zero", 1, 0, 1, 0, 0, 0, 1, -2048, -1, 0, 0, 1'b0);
    run("tie", 1, 1, 3, 0, 0, 2, 13, 7, 1, 1, 1, 1'b1);

    @(negedge clk);
    bus.start = 1'b1;
    bus.len_x = 8'd2;
    bus.len_y = 8'd2;
    bus.len_z = 8'd2;
    bus.rd_ack = 1'b1;
    bus.wr_ack = 1'b1;
    bus.score_in = '0;
    @(posedge clk);
    #1 bus.start = 1'b0;
    t = 0;
    while (!bus.cap_en && t < 20) begin
      @(negedge clk);
      #1 t++;
    end
    chk("mid_cap", bus.cap_en, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_busy", bus.busy, 0);
    chk("mid_rd", bus.rd_req | bus.wr_req, 0);
    chk("mid_cell", {bus.cell_i, bus.cell_j, bus.cell_k}, 0);
    chk("mid_best", bus.best_score, 0);
    bus.rd_ack = 1'b0;
    bus.wr_ack = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("mid_nodone", bus.done, 0);
    end
    rst = 1'b0;

`ifdef ABORT_EN
    @(negedge clk);
    bus.start = 1'b1;
    bus.len_x = 8'd1;
    bus.len_y = 8'd1;
    bus.len_z = 8'd3;
    bus.rd_ack = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    t = 0;
    while (!bus.wr_req && t < 20) begin
      @(negedge clk);
      #1 t++;
    end
    chk("ab_wr", bus.wr_req, 1);
    bus.wr_ack = 1'b1;
    bus.score_in = 12'sd9;
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    bus.wr_ack = 1'b0;
    bus.rd_ack = 1'b0;
    chk("ab_pulse", bus.aborted, 1);
    chk("ab_busy", bus.busy, 0);
    chk("ab_done", bus.done, 0);
    chk("ab_wrreq", bus.wr_req, 0);
    chk("ab_best", bus.best_score, -2048);
    @(posedge clk);
    #1;
    chk("ab_clear", bus.aborted, 0);
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    chk("ab_idle", bus.aborted, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
